// File: rtl/knight_tour_solver.sv
// knight_tour_solver: depth-first backtracking search for a knight's tour
// on a 5x5 board. Candidate moves are tried lowest bit first, so the tour is
// deterministic for a given start square. The 24 moves taken are held in
// mv[] and read combinationally by the downstream command converter.
module knight_tour_solver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [2:0] x_start,
  input  logic [2:0] y_start,
  input  logic [4:0] indx,
  output logic [7:0] move,
  output logic       busy,
  output logic       done,
  output logic       fail
);

  typedef enum logic [2:0] {
    IDLE, INIT, POSSIBLE, MAKE_MOVE, BACKUP, DONE, FAIL
  } state_t;

  state_t      state;
  logic [24:0] visited;
  logic [2:0]  x, y;
  logic [2:0]  x0, y0;
  logic [4:0]  lvl;
  logic [7:0]  rem [24];
  logic [7:0]  mv  [24];

  logic [7:0]        cur_rem, pick, back_mv;
  logic signed [3:0] nx, ny, px, py;
  logic [4:0]        lvl_m1;
  logic              unused_sign;

  // Column offset of a one-hot move code.
  function automatic logic signed [3:0] off_x(input logic [7:0] b);
    case (b)
      8'h01:   off_x = -4'sd1;
      8'h02:   off_x =  4'sd1;
      8'h04:   off_x = -4'sd2;
      8'h08:   off_x = -4'sd2;
      8'h10:   off_x = -4'sd1;
      8'h20:   off_x =  4'sd1;
      8'h40:   off_x =  4'sd2;
      8'h80:   off_x =  4'sd2;
      default: off_x =  4'sd0;
    endcase
  endfunction

  // Row offset of a one-hot move code (north is +y).
  function automatic logic signed [3:0] off_y(input logic [7:0] b);
    case (b)
      8'h01:   off_y =  4'sd2;
      8'h02:   off_y =  4'sd2;
      8'h04:   off_y =  4'sd1;
      8'h08:   off_y = -4'sd1;
      8'h10:   off_y = -4'sd2;
      8'h20:   off_y = -4'sd2;
      8'h40:   off_y = -4'sd1;
      8'h80:   off_y =  4'sd1;
      default: off_y =  4'sd0;
    endcase
  endfunction

  // Linear square number, row-major from the south-west corner.
  function automatic logic [4:0] sq(input logic [2:0] cx, input logic [2:0] cy);
    sq = {2'b00, cy} * 5'd5 + {2'b00, cx};
  endfunction

  // Moves from (cx, cy) that stay on the board and land on an unvisited square.
  function automatic logic [7:0] legal_moves(input logic [2:0] cx, input logic [2:0] cy,
                                             input logic [24:0] vis);
    logic signed [3:0] tx, ty;
    logic [7:0]        b;
    legal_moves = '0;
    for (int k = 0; k < 8; k++) begin
      b  = 8'd1 << k;
      tx = $signed({1'b0, cx}) + off_x(b);
      ty = $signed({1'b0, cy}) + off_y(b);
      if (tx >= 4'sd0 && tx <= 4'sd4 && ty >= 4'sd0 && ty <= 4'sd4) begin
        if (!vis[sq(tx[2:0], ty[2:0])]) legal_moves[k] = 1'b1;
      end
    end
  endfunction

  // Next-step arithmetic: lowest untried move forward, last move undone backward.
  always_comb begin
    lvl_m1  = lvl - 5'd1;
    cur_rem = rem[lvl];
    pick    = cur_rem & (~cur_rem + 8'd1);
    back_mv = mv[lvl_m1];
    nx      = $signed({1'b0, x}) + off_x(pick);
    ny      = $signed({1'b0, y}) + off_y(pick);
    px      = $signed({1'b0, x}) - off_x(back_mv);
    py      = $signed({1'b0, y}) - off_y(back_mv);
  end

  // Sign bits are dropped once the on-board check has already passed.
  assign unused_sign = ^{nx[3], ny[3], px[3], py[3]};

  // Downstream read port; indices past the last move read as no move.
  assign move = (indx < 5'd24) ? mv[indx] : 8'd0;

  // Search controller with registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
      visited <= '0;
      x       <= '0;
      y       <= '0;
      x0      <= '0;
      y0      <= '0;
      lvl     <= '0;
      for (int i = 0; i < 24; i++) begin
        rem[i] <= '0;
        mv[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE, FAIL: begin
          if (go) begin
            x0   <= x_start;
            y0   <= y_start;
            done <= 1'b0;
            fail <= 1'b0;
            if (x_start > 3'd4 || y_start > 3'd4 || (x_start[0] ^ y_start[0])) begin
              state <= FAIL;
              fail  <= 1'b1;
            end else begin
              state <= INIT;
              busy  <= 1'b1;
            end
          end
        end
        INIT: begin
          visited <= 25'd1 << sq(x0, y0);
          x       <= x0;
          y       <= y0;
          lvl     <= '0;
          for (int i = 0; i < 24; i++) mv[i] <= '0;
          state   <= POSSIBLE;
        end
        POSSIBLE: begin
          rem[lvl] <= legal_moves(x, y, visited);
          state    <= MAKE_MOVE;
        end
        MAKE_MOVE: begin
          if (cur_rem != 8'd0) begin
            rem[lvl] <= cur_rem & ~pick;
            mv[lvl]  <= pick;
            x        <= nx[2:0];
            y        <= ny[2:0];
            visited  <= visited | (25'd1 << sq(nx[2:0], ny[2:0]));
            lvl      <= lvl + 5'd1;
            if (lvl == 5'd23) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= POSSIBLE;
            end
          end else begin
            state <= BACKUP;
          end
        end
        BACKUP: begin
          if (lvl == 5'd0) begin
            state <= FAIL;
            fail  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            visited <= visited & ~(25'd1 << sq(x, y));
            lvl     <= lvl_m1;
            x       <= px[2:0];
            y       <= py[2:0];
            state   <= MAKE_MOVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knight_tour_solver.sv
// tb_knight_tour_solver: directed bench for the 5x5 knight's tour solver.
// A software depth-first search supplies the expected move list and the
// go-to-done latency; each tour is also replayed on a board to confirm it
// covers all 25 squares exactly once.
module tb_knight_tour_solver;

  logic       clk;
  logic       rst_n;
  logic       go;
  logic [2:0] x_start;
  logic [2:0] y_start;
  logic [4:0] indx;
  logic [7:0] move;
  logic       busy;
  logic       done;
  logic       fail;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int dxs [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
  int dys [8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};

  logic [7:0] exp_mv [24];
  int         exp_cycles;
  int         cyc;

  knight_tour_solver dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go),
    .x_start (x_start),
    .y_start (y_start),
    .indx    (indx),
    .move    (move),
    .busy    (busy),
    .done    (done),
    .fail    (fail)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bit_of(input logic [7:0] m);
    bit_of = 0;
    for (int j = 0; j < 8; j++) if (m[j]) bit_of = j;
  endfunction

  // Reference search: lowest move bit first, backtracking on dead ends.
  task automatic run_model(input int sx, input int sy);
    bit [24:0] vis;
    bit [7:0]  rem [24];
    int        x, y, lvl, fwd, bck, k;
    bit        need;
    vis = '0;
    x = sx;
    y = sy;
    vis[y * 5 + x] = 1'b1;
    lvl = 0;
    fwd = 0;
    bck = 0;
    need = 1'b1;
    for (int i = 0; i < 24; i++) begin
      exp_mv[i] = 8'd0;
      rem[i] = 8'd0;
    end
    for (int step = 0; step < 4000000; step++) begin
      if (need) begin
        rem[lvl] = 8'd0;
        for (int j = 0; j < 8; j++) begin
          int tx, ty;
          tx = x + dxs[j];
          ty = y + dys[j];
          if (tx >= 0 && tx < 5 && ty >= 0 && ty < 5)
            if (!vis[ty * 5 + tx]) rem[lvl][j] = 1'b1;
        end
      end
      if (rem[lvl] != 8'd0) begin
        k = 0;
        while (!rem[lvl][k]) k++;
        rem[lvl][k] = 1'b0;
        exp_mv[lvl] = 8'd1 << k;
        x += dxs[k];
        y += dys[k];
        vis[y * 5 + x] = 1'b1;
        lvl++;
        fwd++;
        if (lvl == 24) break;
        need = 1'b1;
      end else begin
        bck++;
        if (lvl == 0) break;
        vis[y * 5 + x] = 1'b0;
        lvl--;
        k = bit_of(exp_mv[lvl]);
        x -= dxs[k];
        y -= dys[k];
        need = 1'b0;
      end
    end
    exp_cycles = 1 + 2 * fwd + 2 * bck;
  endtask

  task automatic pulse_go(input logic [2:0] sx, input logic [2:0] sy);
    x_start = sx;
    y_start = sy;
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  task automatic wait_end(inout int c, input int limit);
    while (done !== 1'b1 && fail !== 1'b1 && c < limit) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic check_finish(input string tag);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_fail"}, fail, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_latency"}, cyc, exp_cycles);
  endtask

  // Read every move back, compare with the model and replay it on a board.
  task automatic check_tour(input string tag, input int sx, input int sy);
    bit [24:0]  seen;
    int         x, y, k;
    bit         ok_hot, ok_path;
    logic [7:0] m;
    seen = '0;
    x = sx;
    y = sy;
    seen[y * 5 + x] = 1'b1;
    ok_hot = 1'b1;
    ok_path = 1'b1;
    for (int i = 0; i < 24; i++) begin
      indx = 5'(i);
      #1;
      m = move;
      check($sformatf("%s_mv%0d", tag, i), m, exp_mv[i]);
      if ($countones(m) != 1) begin
        ok_hot = 1'b0;
      end else begin
        k = bit_of(m);
        x += dxs[k];
        y += dys[k];
        if (x < 0 || x > 4 || y < 0 || y > 4) ok_path = 1'b0;
        else if (seen[y * 5 + x]) ok_path = 1'b0;
        else seen[y * 5 + x] = 1'b1;
      end
    end
    check({tag, "_onehot"}, ok_hot, 1'b1);
    check({tag, "_path"}, ok_path, 1'b1);
    check({tag, "_cover"}, seen, 25'h1FF_FFFF);
    indx = 5'd0;
    #1;
  endtask

  initial begin
    logic [7:0] acc;
    rst_n = 1'b0;
    go = 1'b0;
    x_start = 3'd0;
    y_start = 3'd0;
    indx = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_move", move, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fail", fail, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Odd-parity start: immediate failure, no search
    pulse_go(3'd0, 3'd1);
    check("odd_fail", fail, 1'b1);
    check("odd_busy", busy, 1'b0);
    check("odd_done", done, 1'b0);
    @(posedge clk);
    #1;
    check("odd_busy_later", busy, 1'b0);
    check("odd_fail_held", fail, 1'b1);
    acc = 8'd0;
    for (int i = 0; i < 32; i++) begin
      indx = 5'(i);
      #1;
      acc = acc | move;
    end
    indx = 5'd0;
    check("odd_moves_zero", acc, 8'd0);

    // Out-of-range start
    pulse_go(3'd5, 3'd0);
    check("range_fail", fail, 1'b1);
    check("range_done", done, 1'b0);
    check("range_busy", busy, 1'b0);

    // Centre start
    run_model(2, 2);
    pulse_go(3'd2, 3'd2);
    check("c22_busy_start", busy, 1'b1);
    check("c22_fail_clear", fail, 1'b0);
    cyc = 0;
    wait_end(cyc, exp_cycles + 50);
    check_finish("c22");
    check_tour("c22", 2, 2);

    // Corner (0,0) then (4,4) back to back
    run_model(0, 0);
    pulse_go(3'd0, 3'd0);
    cyc = 0;
    wait_end(cyc, exp_cycles + 50);
    check_finish("c00");
    check_tour("c00", 0, 0);
    run_model(4, 4);
    pulse_go(3'd4, 3'd4);
    check("c44_done_fall", done, 1'b0);
    check("c44_busy", busy, 1'b1);
    cyc = 0;
    @(posedge clk);
    #1;
    cyc++;
    check("c44_mv_cleared", move, 8'd0);
    wait_end(cyc, exp_cycles + 50);
    check_finish("c44");
    check_tour("c44", 4, 4);

    // Centre start with a stray go mid-solve
    run_model(2, 2);
    pulse_go(3'd2, 3'd2);
    cyc = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    pulse_go(3'd0, 3'd0);
    cyc++;
    check("mid_go_busy", busy, 1'b1);
    wait_end(cyc, exp_cycles + 50);
    check_finish("midgo");
    check_tour("midgo", 2, 2);

    // Reset in the middle of a solve
    pulse_go(3'd2, 3'd2);
    repeat (20) @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_fail", fail, 1'b0);
    check("abort_move", move, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_idle_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
